key_mode_sel: RTL and testbench
===============================

KEY_MODE_SEL -- requirements
Module: key_mode_sel

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning the number of consecutive stable cycles needed to accept a key level (20 ms at 50 MHz); legal range 2..2^20.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port key_ask_n, input, 1 bit: raw asynchronous push-button, low when pressed, selects ASK.
REQ-005 SHALL have port key_fsk_n, input, 1 bit: raw push-button, low when pressed, selects FSK.
REQ-006 SHALL have port key_psk_n, input, 1 bit: raw push-button, low when pressed, selects PSK.
REQ-007 SHALL have port key_dpsk_n, input, 1 bit: raw push-button, low when pressed, selects DPSK.
REQ-008 SHALL have port key_next_n, input, 1 bit: raw push-button, low when pressed, steps to the next mode.
REQ-009 SHALL have ports set_ask, set_fsk, set_psk, set_dpsk, each output, 1 bit, registered: active-low one-hot mode select for the modulator output mux.
REQ-010 SHALL have port mode_code, output, 2 bits, registered: 0=ASK, 1=FSK, 2=PSK, 3=DPSK.
REQ-011 SHALL have port mode_changed, output, 1 bit, registered: one-cycle pulse when mode_code changes value.

Function
REQ-012 Each raw key SHALL pass through a 2-flop synchronizer and then a debounce counter.
REQ-013 Debounce: while the synchronized level differs from the debounced state, the counter SHALL increment each cycle; when it reaches DEBOUNCE_CYCLES-1 the debounced state SHALL take the new level and the counter SHALL clear; any cycle with equal levels SHALL clear the counter.
REQ-014 A press event SHALL be a one-cycle registered pulse on the debounced 1->0 transition only; releases and held keys SHALL generate no events (no auto-repeat).
REQ-015 The mode register SHALL update on the clock edge after the press pulse, so outputs change exactly DEBOUNCE_CYCLES+3 edges after the first edge that samples a stable low raw key.
REQ-016 A direct-key press SHALL load its mode; a next press SHALL step ASK->FSK->PSK->DPSK->ASK, wrapping from 3 to 0.
REQ-017 Simultaneous press events SHALL resolve by priority: ASK > FSK > PSK > DPSK > next.
REQ-018 The set_* outputs SHALL always equal the one-hot decode of mode_code: ASK=0111, FSK=1011, PSK=1101, DPSK=1110 for {set_ask,set_fsk,set_psk,set_dpsk}; no other pattern is legal.
REQ-019 mode_changed SHALL pulse high for one cycle, aligned with the output update, only when the new mode differs from the old one; reselecting the current mode SHALL not pulse.

Reset
REQ-020 While reset is high: mode_code=0, set_*=0111, mode_changed=0, all synchronizers and debounced states=1 (released), all counters=0.
REQ-021 A key held low through reset deassertion SHALL be treated as a new press after full debounce; reset asserted mid-debounce SHALL abort it with no event.

Structure
REQ-022 The shared package SHALL hold the mode_code encodings, the 4-bit one-hot set patterns, and the DEBOUNCE_CYCLES default.
REQ-023 The design SHALL use one sub-module, key_debounce (synchronizer, counter, and press pulse), instantiated five times.

Verification (DEBOUNCE_CYCLES=8)
REQ-024 Reset, then hold key_fsk_n low: mode_code 0->1 and set_*=1011 on edge 11, with mode_changed high for exactly that cycle.
REQ-025 Bounce key_psk_n low for 5 cycles and high for 1, repeated 3 times: no mode change; then hold low for 8 stable cycles: mode becomes 2, 1101.
REQ-026 Issue 4 debounced presses of key_next_n starting from ASK: sequence is 1, 2, 3, 0, with four mode_changed pulses.
REQ-027 Press key_ask_n and key_dpsk_n in the same cycle: mode becomes 0; starting from ASK, no mode_changed pulse.
REQ-028 Hold key_dpsk_n for 100 cycles, then release: exactly one change to 3 and no event on release; reset at cycle 5 of a debounce leaves mode 0 and set_*=0111.

Source files
------------

// File: rtl/key_mode_sel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : key_mode_sel_pkg
// Description : Shared definitions for the modulation-mode key selector:
//               mode_code encodings, active-low one-hot select patterns,
//               key index map and the default debounce length.
//               Ports: none (package).
// Revision    : 1.0 - initial release
// ============================================================================
package key_mode_sel_pkg;

    typedef enum logic [1:0] {
        MODE_ASK  = 2'd0,
        MODE_FSK  = 2'd1,
        MODE_PSK  = 2'd2,
        MODE_DPSK = 2'd3
    } mode_e;

    // {set_ask, set_fsk, set_psk, set_dpsk}, active low
    localparam logic [3:0] SET_ASK_PAT  = 4'b0111;
    localparam logic [3:0] SET_FSK_PAT  = 4'b1011;
    localparam logic [3:0] SET_PSK_PAT  = 4'b1101;
    localparam logic [3:0] SET_DPSK_PAT = 4'b1110;

    // 20 ms at 50 MHz
    localparam int DEBOUNCE_CYCLES_DEF = 1000000;

    // Bit positions of the keys in the packed key vector (also the priority
    // order: lower index wins)
    localparam int KEY_ASK  = 0;
    localparam int KEY_FSK  = 1;
    localparam int KEY_PSK  = 2;
    localparam int KEY_DPSK = 3;
    localparam int KEY_NEXT = 4;
    localparam int NUM_KEYS = 5;

    function automatic logic [3:0] set_decode(input mode_e m);
        logic [3:0] pat;
        pat = SET_ASK_PAT;
        case (m)
            MODE_ASK:  pat = SET_ASK_PAT;
            MODE_FSK:  pat = SET_FSK_PAT;
            MODE_PSK:  pat = SET_PSK_PAT;
            MODE_DPSK: pat = SET_DPSK_PAT;
            default:   pat = SET_ASK_PAT;
        endcase
        return pat;
    endfunction

endpackage : key_mode_sel_pkg
`default_nettype wire

// File: rtl/key_mode_sel_debounce.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce
// Description : Two-flop synchronizer, debounce counter and one-cycle press
//               pulse for one active-low push-button.
//               clk      - clock (rising edge)
//               reset    - asynchronous active-high reset
//               key_n_i  - raw active-low key
//               press_o  - registered one-cycle pulse on debounced 1->0
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce
    import key_mode_sel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n_i,
    output logic press_o
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    // The counter value seen on the edge that accepts the new level; the
    // count notionally reaches DEBOUNCE_CYCLES-1 on that same edge.
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 2);

    logic          sync1_q, sync2_q;
    logic          deb_q, deb_d;
    logic          deb_dly_q;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (cnt_q == CNT_LAST) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        // Falling debounced level only; releases and holds give nothing.
        press_d = deb_dly_q & ~deb_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            deb_q     <= 1'b1;
            deb_dly_q <= 1'b1;
            press_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= key_n_i;
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            deb_dly_q <= deb_q;
            press_q   <= press_d;
            cnt_q     <= cnt_d;
        end
    end

    assign press_o = press_q;

endmodule : key_debounce
`default_nettype wire

// File: rtl/key_mode_sel.sv
`default_nettype none
// ============================================================================
// Module      : key_mode_sel
// Description : Modulation mode selector driven by five push-buttons.
//               clk          - clock (rising edge)
//               reset        - asynchronous active-high reset
//               key_*_n      - raw active-low keys (ask/fsk/psk/dpsk/next)
//               set_*        - registered active-low one-hot mode select
//               mode_code    - registered mode (0 ASK,1 FSK,2 PSK,3 DPSK)
//               mode_changed - one-cycle pulse aligned with a mode change
// Revision    : 1.0 - initial release
// ============================================================================
module key_mode_sel
    import key_mode_sel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_ask_n,
    input  logic       key_fsk_n,
    input  logic       key_psk_n,
    input  logic       key_dpsk_n,
    input  logic       key_next_n,
    output logic       set_ask,
    output logic       set_fsk,
    output logic       set_psk,
    output logic       set_dpsk,
    output logic [1:0] mode_code,
    output logic       mode_changed
);

    logic [NUM_KEYS-1:0] w_keys_n;
    logic [NUM_KEYS-1:0] w_press;

    mode_e      mode_q, mode_d;
    logic [3:0] set_q, set_d;
    logic       changed_q, changed_d;

    assign w_keys_n = {key_next_n, key_dpsk_n, key_psk_n, key_fsk_n, key_ask_n};

    generate
        for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
            key_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_key_debounce (
                .clk     (clk),
                .reset   (reset),
                .key_n_i (w_keys_n[i]),
                .press_o (w_press[i])
            );
        end
    endgenerate

    always_comb begin
        mode_d = mode_q;
        if (w_press[KEY_ASK]) begin
            mode_d = MODE_ASK;
        end else if (w_press[KEY_FSK]) begin
            mode_d = MODE_FSK;
        end else if (w_press[KEY_PSK]) begin
            mode_d = MODE_PSK;
        end else if (w_press[KEY_DPSK]) begin
            mode_d = MODE_DPSK;
        end else if (w_press[KEY_NEXT]) begin
            // 2-bit add wraps DPSK back to ASK
            mode_d = mode_e'(mode_q + 2'd1);
        end
        changed_d = (mode_d != mode_q);
        set_d     = set_decode(mode_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q    <= MODE_ASK;
            set_q     <= SET_ASK_PAT;
            changed_q <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            set_q     <= set_d;
            changed_q <= changed_d;
        end
    end

    assign mode_code    = mode_q;
    assign mode_changed = changed_q;
    assign {set_ask, set_fsk, set_psk, set_dpsk} = set_q;

endmodule : key_mode_sel
`default_nettype wire

// File: tb/tb_key_mode_sel.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_mode_sel
// Description : Directed self-checking bench for key_mode_sel with a short
//               debounce length. Expected mode/select pairs are queued when
//               a press is driven and checked when mode_changed pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_mode_sel;

    localparam int DEB = 8;

    typedef struct packed {
        logic [1:0] mode;
        logic [3:0] set;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [4:0] keys_n;   // bit0 ask, 1 fsk, 2 psk, 3 dpsk, 4 next
    logic       set_ask, set_fsk, set_psk, set_dpsk;
    logic [1:0] mode_code;
    logic       mode_changed;

    exp_t sb_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   pulses   = 0;
    int   p0;

    key_mode_sel #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk          (clk),
        .reset        (reset),
        .key_ask_n    (keys_n[0]),
        .key_fsk_n    (keys_n[1]),
        .key_psk_n    (keys_n[2]),
        .key_dpsk_n   (keys_n[3]),
        .key_next_n   (keys_n[4]),
        .set_ask      (set_ask),
        .set_fsk      (set_fsk),
        .set_psk      (set_psk),
        .set_dpsk     (set_dpsk),
        .mode_code    (mode_code),
        .mode_changed (mode_changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [3:0] set_vec = {set_ask, set_fsk, set_psk, set_dpsk};

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every mode_changed pulse must match the oldest queued entry
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mode_changed === 1'b1) begin
                pulses++;
                if (sb_q.size() == 0) begin
                    chk("unexpected_change", 1, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("sb_mode", int'(mode_code), int'(e.mode));
                    chk("sb_set", int'(set_vec), int'(e.set));
                end
            end
        end
    end

    task automatic push(input logic [1:0] m, input logic [3:0] s);
        exp_t e;
        e.mode = m;
        e.set  = s;
        sb_q.push_back(e);
    endtask

    // Hold the selected keys low long enough to debounce, then release
    task automatic press(input logic [4:0] mask);
        @(negedge clk);
        keys_n = ~mask;
        repeat (14) @(negedge clk);
        keys_n = '1;
        repeat (14) @(negedge clk);
    endtask

    initial begin
        int k;
        reset  = 1'b1;
        keys_n = '1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mode", int'(mode_code), 0);
        chk("rst_set", int'(set_vec), 'h7);
        chk("rst_changed", int'(mode_changed), 0);

        // FSK held from edge 1: change lands exactly on edge 11
        @(negedge clk) reset = 1'b0;
        @(negedge clk);
        keys_n[1] = 1'b0;
        push(2'd1, 4'b1011);
        repeat (10) @(posedge clk);
        #1;
        chk("fsk_edge10_mode", int'(mode_code), 0);
        chk("fsk_edge10_changed", int'(mode_changed), 0);
        @(posedge clk);
        #1;
        chk("fsk_edge11_mode", int'(mode_code), 1);
        chk("fsk_edge11_set", int'(set_vec), 'hB);
        chk("fsk_edge11_changed", int'(mode_changed), 1);
        @(posedge clk);
        #1;
        chk("fsk_pulse_width", int'(mode_changed), 0);
        @(negedge clk) keys_n = '1;
        repeat (20) @(negedge clk);

        // PSK bounce: 5 low / 1 high, three times, never accepted
        p0 = pulses;
        for (int r = 0; r < 3; r++) begin
            keys_n[2] = 1'b0;
            repeat (5) @(negedge clk);
            keys_n[2] = 1'b1;
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        chk("bounce_mode", int'(mode_code), 1);
        chk("bounce_pulses", pulses - p0, 0);
        keys_n[2] = 1'b0;
        push(2'd2, 4'b1101);
        repeat (14) @(negedge clk);
        chk("psk_stable_mode", int'(mode_code), 2);
        chk("psk_stable_set", int'(set_vec), 'hD);
        keys_n[2] = 1'b1;
        repeat (14) @(negedge clk);

        // Back to ASK, then four NEXT presses: 1,2,3,0
        push(2'd0, 4'b0111);
        press(5'b00001);
        p0 = pulses;
        push(2'd1, 4'b1011);
        press(5'b10000);
        push(2'd2, 4'b1101);
        press(5'b10000);
        push(2'd3, 4'b1110);
        press(5'b10000);
        push(2'd0, 4'b0111);
        press(5'b10000);
        chk("next_pulses", pulses - p0, 4);
        chk("next_wrap_mode", int'(mode_code), 0);

        // ASK and DPSK together from ASK: ASK wins, no pulse
        p0 = pulses;
        press(5'b01001);
        chk("prio_mode", int'(mode_code), 0);
        chk("prio_set", int'(set_vec), 'h7);
        chk("prio_pulses", pulses - p0, 0);

        // DPSK held 100 cycles: one change, nothing on release
        p0 = pulses;
        push(2'd3, 4'b1110);
        @(negedge clk);
        keys_n[3] = 1'b0;
        repeat (100) @(negedge clk);
        keys_n[3] = 1'b1;
        repeat (20) @(negedge clk);
        chk("dpsk_hold_mode", int'(mode_code), 3);
        chk("dpsk_hold_pulses", pulses - p0, 1);

        // Reset on cycle 5 of an FSK debounce aborts it
        p0 = pulses;
        @(negedge clk);
        keys_n[1] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_mid_async_mode", int'(mode_code), 0);
        @(negedge clk) keys_n = '1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("rst_mid_mode", int'(mode_code), 0);
        chk("rst_mid_set", int'(set_vec), 'h7);
        chk("rst_mid_pulses", pulses - p0, 0);

        // Key held low through reset deassertion is a fresh press
        @(negedge clk);
        reset     = 1'b1;
        keys_n[1] = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        push(2'd1, 4'b1011);
        k = 0;
        while (mode_changed !== 1'b1 && k < 30) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("held_rst_seen", int'(mode_changed), 1);
        chk("held_rst_latency", k, 11);
        chk("held_rst_mode", int'(mode_code), 1);
        @(negedge clk) keys_n = '1;
        repeat (20) @(negedge clk);

        chk("sb_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_key_mode_sel
`default_nettype wire
